pipe_chain: RTL and testbench

PIPE_CHAIN -- requirements
Module: pipe_chain

---
 rtl/pipe_chain_if.sv | 27 ++
 rtl/pipe_chain.sv | 84 ++++++++
 tb/tb_pipe_chain.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_chain_if.sv
// Handshake bundle for the stallable/flushable pipeline chain.
// master drives the stream and control bits, slave is the chain itself.
interface pipe_chain_if #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int CW     = $clog2(STAGES + 1)
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic [STAGES-1:0] stall;
    logic [STAGES-1:0] flush;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [CW-1:0]     count;

    modport master (
        output in_valid, in_data, stall, flush, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, stall, flush, out_ready,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/pipe_chain.sv
// Valid/ready register chain with per-stage stall and flush (kill).
// Ready ripples combinationally from out_ready so full chains stream.
module pipe_chain #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int CW     = $clog2(STAGES + 1)
) (
    input logic         clk,
    input logic         rst,
    pipe_chain_if.slave bus
);
    logic [STAGES-1:0] valid;
    logic [STAGES-1:0] validNext;
    logic [STAGES-1:0] ready;
    logic [STAGES-1:0] depart;
    logic [STAGES-1:0] upValid;
    logic [WIDTH-1:0]  data   [STAGES];
    logic [WIDTH-1:0]  upData [STAGES];
    logic [CW-1:0]     countQ;
    logic [CW-1:0]     countNext;

    // Walk from the output back to stage 0 so each ready sees its successor.
    always_comb begin : readyChain
        logic rdyDown;
        rdyDown = bus.out_ready;
        depart  = '0;
        ready   = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            depart[k] = valid[k] & ~bus.stall[k] & rdyDown;
            ready[k]  = ~bus.stall[k] & (~valid[k] | depart[k]);
            rdyDown   = ready[k];
        end
    end

    always_comb begin
        upValid    = '0;
        upValid[0] = bus.in_valid;
        upData[0]  = bus.in_data;
        for (int k = 1; k < STAGES; k++) begin
            upValid[k] = depart[k-1];
            upData[k]  = data[k-1];
        end
    end

    always_comb begin
        validNext = '0;
        countNext = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (bus.flush[k]) begin
                validNext[k] = 1'b0;
            end else if (ready[k]) begin
                validNext[k] = upValid[k];
            end else begin
                validNext[k] = valid[k];
            end
            countNext = countNext + CW'(validNext[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid  <= '0;
            countQ <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data[k] <= '0;
            end
        end else begin
            valid  <= validNext;
            countQ <= countNext;
            for (int k = 0; k < STAGES; k++) begin
                if (bus.flush[k]) begin
                    data[k] <= '0;
                end else if (ready[k]) begin
                    data[k] <= upData[k];
                end
            end
        end
    end

    assign bus.in_ready  = ready[0];
    assign bus.out_valid = valid[STAGES-1] & ~bus.stall[STAGES-1];
    assign bus.out_data  = data[STAGES-1];
    assign bus.count     = countQ;
endmodule

// File: tb/tb_pipe_chain.sv
// Random and directed stimulus against an item-position queue model.
// Monitor pops expected items as the chain delivers them.
module tb_pipe_chain;
    localparam int W = 32;
    localparam int S = 4;

    typedef struct {
        logic [W-1:0] data;
        int           pos;
    } item_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    item_t q[$];

    pipe_chain_if #(.WIDTH(W), .STAGES(S)) bus ();

    pipe_chain #(.WIDTH(W), .STAGES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: items keep their stage index; an item advances when its
    // stage is free to move and the stage ahead is unstalled and emptying.
    task automatic modelStep();
        bit     occ   [S];
        bit     moved [S];
        bit     expReady;
        bit     expOv;
        item_t  it;
        item_t  keep[$];
        for (int p = 0; p < S; p++) begin
            occ[p]   = 1'b0;
            moved[p] = 1'b0;
        end
        foreach (q[i]) occ[q[i].pos] = 1'b1;
        foreach (q[i]) begin
            int p;
            p = q[i].pos;
            if (p == S - 1) begin
                moved[p] = !bus.stall[p] && bus.out_ready;
            end else begin
                moved[p] = !bus.stall[p] && !bus.stall[p+1] &&
                           (!occ[p+1] || moved[p+1]);
            end
        end
        expReady = !bus.stall[0] && (!occ[0] || moved[0]);
        expOv    = occ[S-1] && !bus.stall[S-1];
        chk("in_ready", W'(bus.in_ready), W'(expReady));
        chk("out_valid", W'(bus.out_valid), W'(expOv));
        chk("count", W'(bus.count), W'(q.size()));
        if (expOv) chk("out_data", bus.out_data, q[0].data);
        if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_out", 32'd1, 32'd0);
            end else begin
                it = q.pop_front();
                chk("out_item", bus.out_data, it.data);
            end
        end
        foreach (q[i]) if (moved[q[i].pos]) q[i].pos++;
        if (bus.in_valid && expReady) begin
            it.data = bus.in_data;
            it.pos  = 0;
            q.push_back(it);
        end
        foreach (q[i]) if (!bus.flush[q[i].pos]) keep.push_back(q[i]);
        q = keep;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            chk("rst_count", W'(bus.count), '0);
            chk("rst_out_valid", W'(bus.out_valid), '0);
            chk("rst_out_data", bus.out_data, '0);
            chk("rst_in_ready", W'(bus.in_ready), W'(!bus.stall[0]));
        end else begin
            modelStep();
        end
    end

    task automatic step(input logic iv, input logic [W-1:0] id,
                        input logic [S-1:0] st, input logic [S-1:0] fl,
                        input logic ordy, output logic acc);
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.stall     = st;
        bus.flush     = fl;
        bus.out_ready = ordy;
        @(negedge clk);
        acc = iv & bus.in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic ordy);
        logic acc;
        repeat (n) step(1'b0, '0, '0, '0, ordy, acc);
    endtask

    task automatic stream(input logic [W-1:0] base, input int n,
                          input int stallAt, input logic ordy);
        logic         acc;
        logic [S-1:0] st;
        int           sent;
        int           cyc;
        sent = 0;
        cyc  = 0;
        while (sent < n && cyc < 100) begin
            st = (cyc >= stallAt && cyc < stallAt + 2) ? 4'b0100 : 4'b0000;
            step(1'b1, base + W'(sent), st, '0, ordy, acc);
            if (acc) sent++;
            cyc++;
        end
        chk("stream_sent", W'(sent), W'(n));
    endtask

    initial begin
        logic         acc;
        logic [S-1:0] st;
        logic [S-1:0] fl;
        int           lat;
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.stall     = '0;
        bus.flush     = '0;
        bus.out_ready = 1'b1;
        #3;
        chk("init_count", W'(bus.count), '0);
        chk("init_out_valid", W'(bus.out_valid), '0);
        chk("init_out_data", bus.out_data, '0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        stream(32'h10, 8, -10, 1'b1);
        idle(6, 1'b1);

        stream(32'hA0, 4, -10, 1'b0);
        idle(3, 1'b0);
        chk("bp_count", W'(bus.count), 32'd4);
        chk("bp_in_ready", W'(bus.in_ready), '0);
        chk("bp_out_data", bus.out_data, 32'hA0);
        idle(6, 1'b1);

        stream(32'h20, 10, 3, 1'b1);
        idle(6, 1'b1);

        step(1'b1, 32'h55, '0, '0, 1'b1, acc);
        step(1'b1, 32'h66, '0, '0, 1'b1, acc);
        step(1'b0, '0, 4'b0100, 4'b0010, 1'b1, acc);
        chk("flush_count", W'(bus.count), 32'd1);
        idle(6, 1'b1);

        for (int c = 0; c < 500; c++) begin
            for (int b = 0; b < S; b++) begin
                st[b] = ($urandom_range(0, 7) == 0);
                fl[b] = ($urandom_range(0, 19) == 0);
            end
            step($urandom_range(0, 3) != 0, $urandom, st, fl,
                 $urandom_range(0, 3) != 0, acc);
        end
        idle(8, 1'b1);

        stream(32'h30, 3, -10, 1'b0);
        chk("pre_rst_count", W'(bus.count), 32'd3);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_count", W'(bus.count), '0);
        chk("async_out_valid", W'(bus.out_valid), '0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b1, 32'h99, '0, '0, 1'b1, acc);
        chk("lat_accept", W'(acc), 32'd1);
        bus.in_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) break;
            @(posedge clk);
            #1;
        end
        chk("latency", W'(lat), 32'd4);
        chk("lat_data", bus.out_data, 32'h99);
        @(posedge clk);
        #1;
        idle(4, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
